// File: rtl/ysyx_22050854_clint.sv
// ysyx_22050854_clint: machine timer / software interrupt block behind a two-state LSU handshake.
// Build option: define YSYX_22050854_CLINT_MSIP_EN to make msip a real register driving soft_interrupt.
module ysyx_22050854_clint #(
  parameter int TICK_DIV = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_wen,
  input  logic [31:0] req_addr,
  input  logic [63:0] req_wdata,
  input  logic [7:0]  req_wstrb,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [63:0] resp_rdata,
  output logic        resp_err,
  output logic        timer_interrupt,
  output logic        soft_interrupt
);
  localparam logic [31:0] ADDR_MSIP  = 32'h0200_0000;
  localparam logic [31:0] ADDR_CMP   = 32'h0200_4000;
  localparam logic [31:0] ADDR_MTIME = 32'h0200_BFF8;
  localparam logic [7:0]  PRESC_MAX  = 8'(TICK_DIV - 1);

  typedef enum logic {IDLE, RESP} state_t;

  state_t      state;
  logic [63:0] mtime, mtimecmp, mtime_inc, mtime_next, mtimecmp_next;
  logic [63:0] wmask, rdata_sel;
  logic [7:0]  presc, presc_next;
  logic        accept, wr, sel_msip, sel_cmp, sel_mtime, mapped, tick, msip;

  assign req_ready = (state == IDLE);
  assign accept    = req_valid && req_ready;
  assign wr        = accept && req_wen;
  assign sel_msip  = (req_addr == ADDR_MSIP);
  assign sel_cmp   = (req_addr == ADDR_CMP);
  assign sel_mtime = (req_addr == ADDR_MTIME);
  assign mapped    = sel_msip || sel_cmp || sel_mtime;

  always_comb begin
    wmask = '0;
    for (int i = 0; i < 8; i++) wmask[i*8 +: 8] = {8{req_wstrb[i]}};
  end

  // Write bytes override the already-incremented value so a same-edge tick is not lost.
  assign tick          = (presc == PRESC_MAX);
  assign mtime_inc     = tick ? mtime + 64'd1 : mtime;
  assign mtime_next    = (wr && sel_mtime) ? ((req_wdata & wmask) | (mtime_inc & ~wmask)) : mtime_inc;
  assign mtimecmp_next = (wr && sel_cmp) ? ((req_wdata & wmask) | (mtimecmp & ~wmask)) : mtimecmp;
  assign presc_next    = ((wr && sel_mtime) || tick) ? 8'd0 : presc + 8'd1;

`ifdef YSYX_22050854_CLINT_MSIP_EN
  always_ff @(posedge clk) begin
    if (!rst_n) msip <= 1'b0;
    else if (wr && sel_msip && req_wstrb[0]) msip <= req_wdata[0];
  end
`else
  assign msip = 1'b0;
`endif

  assign soft_interrupt = msip;

  always_comb begin
    rdata_sel = '0;
    if (sel_msip)       rdata_sel = {63'd0, msip};
    else if (sel_cmp)   rdata_sel = mtimecmp;
    else if (sel_mtime) rdata_sel = mtime;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state           <= IDLE;
      resp_valid      <= 1'b0;
      resp_rdata      <= '0;
      resp_err        <= 1'b0;
      mtime           <= '0;
      mtimecmp        <= '1;
      presc           <= '0;
      timer_interrupt <= 1'b0;
    end else begin
      mtime           <= mtime_next;
      mtimecmp        <= mtimecmp_next;
      presc           <= presc_next;
      timer_interrupt <= (mtime_next >= mtimecmp_next);
      case (state)
        IDLE: if (accept) begin
          state      <= RESP;
          resp_valid <= 1'b1;
          resp_rdata <= req_wen ? 64'd0 : rdata_sel;
          resp_err   <= !mapped;
        end
        RESP: if (resp_ready) begin
          state      <= IDLE;
          resp_valid <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_ysyx_22050854_clint.sv
// Bench for ysyx_22050854_clint: two instances (TICK_DIV 1 and 4) checked against a time-based model.
module tb_ysyx_22050854_clint;
  localparam logic [31:0] A_MSIP = 32'h0200_0000;
  localparam logic [31:0] A_CMP  = 32'h0200_4000;
  localparam logic [31:0] A_MT   = 32'h0200_BFF8;
  localparam logic [31:0] A_BAD  = 32'h0200_1000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        rv[2], rr[2], wen[2], rsv[2], rsr[2], rerr[2], tirq[2], sirq[2];
  logic [31:0] addr[2];
  logic [63:0] wd[2], rd[2];
  logic [7:0]  ws[2];

  longint      cyc = 0;
  int          n_chk = 0, n_fail = 0;

  // Model: mtime after edge e is base + (e - c0) / tdiv, re-anchored on every mtime write or reset.
  logic [63:0] base[2], cmp[2];
  longint      c0[2];
  logic        msip_m[2];
  int          tdiv[2];

  ysyx_22050854_clint #(.TICK_DIV(1)) dut0 (
    .clk(clk), .rst_n(rst_n), .req_valid(rv[0]), .req_ready(rr[0]), .req_wen(wen[0]),
    .req_addr(addr[0]), .req_wdata(wd[0]), .req_wstrb(ws[0]), .resp_valid(rsv[0]),
    .resp_ready(rsr[0]), .resp_rdata(rd[0]), .resp_err(rerr[0]),
    .timer_interrupt(tirq[0]), .soft_interrupt(sirq[0]));

  ysyx_22050854_clint #(.TICK_DIV(4)) dut1 (
    .clk(clk), .rst_n(rst_n), .req_valid(rv[1]), .req_ready(rr[1]), .req_wen(wen[1]),
    .req_addr(addr[1]), .req_wdata(wd[1]), .req_wstrb(ws[1]), .resp_valid(rsv[1]),
    .resp_ready(rsr[1]), .resp_rdata(rd[1]), .resp_err(rerr[1]),
    .timer_interrupt(tirq[1]), .soft_interrupt(sirq[1]));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [63:0] mt(int d, longint e);
    return base[d] + 64'((e - c0[d]) / longint'(tdiv[d]));
  endfunction

  function automatic logic [63:0] merge(logic [63:0] n, logic [63:0] o, logic [7:0] s);
    logic [63:0] r;
    r = o;
    for (int i = 0; i < 8; i++) if (s[i]) r[i*8 +: 8] = n[i*8 +: 8];
    return r;
  endfunction

  function automatic logic msip_exp(int d);
`ifdef YSYX_22050854_CLINT_MSIP_EN
    return msip_m[d];
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic [63:0] exp_rd(int d, logic [31:0] a, longint ea);
    if (a == A_MSIP) return {63'd0, msip_exp(d)};
    if (a == A_CMP)  return cmp[d];
    if (a == A_MT)   return mt(d, ea - 1);
    return 64'd0;
  endfunction

  function automatic logic exp_err(logic [31:0] a);
    return !(a == A_MSIP || a == A_CMP || a == A_MT);
  endfunction

  function automatic void model_reset(longint e);
    for (int d = 0; d < 2; d++) begin
      base[d] = '0; c0[d] = e; cmp[d] = '1; msip_m[d] = 1'b0;
    end
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    model_reset(cyc);
  endtask

  // Called at a negedge; returns at the negedge after the response handshake edge.
  task automatic access(input int d, input logic w, input logic [31:0] a, input logic [63:0] data,
                        input logic [7:0] strb, input int hold, output logic [63:0] r, output logic e,
                        output longint ea, output logic ok, output logic stable, output logic t_acc);
    logic [63:0] r0;
    logic        e0;
    ok = rr[d];
    rv[d] = 1'b1; wen[d] = w; addr[d] = a; wd[d] = data; ws[d] = strb; rsr[d] = 1'b0;
    @(negedge clk);
    ea = cyc;
    rv[d] = 1'b0; wen[d] = 1'b0;
    ok = ok & rsv[d] & !rr[d];
    t_acc = tirq[d];
    r0 = rd[d]; e0 = rerr[d]; stable = 1'b1;
    repeat (hold) begin
      @(negedge clk);
      stable &= (rsv[d] === 1'b1) && (rd[d] === r0) && (rerr[d] === e0) && (rr[d] === 1'b0);
    end
    r = r0; e = e0;
    rsr[d] = 1'b1;
    @(negedge clk);
    rsr[d] = 1'b0;
    ok = ok & !rsv[d] & rr[d];
    if (w && !exp_err(a)) begin
      if (a == A_MT) begin
        base[d] = merge(data, mt(d, ea), strb);
        c0[d] = ea;
      end else if (a == A_CMP) begin
        cmp[d] = merge(data, cmp[d], strb);
      end else if (strb[0]) begin
        msip_m[d] = data[0];
      end
    end
  endtask

  task automatic test_reset();
    do_reset();
    for (int d = 0; d < 2; d++) begin
      n_chk++;
      if ({rsv[d], rr[d], rerr[d], tirq[d], sirq[d]} !== 5'b01000) begin
        n_fail++;
        $display("FAIL reset_outputs[%0d] got {valid,ready,err,tirq,sirq}=%b want 01000", d,
                 {rsv[d], rr[d], rerr[d], tirq[d], sirq[d]});
      end
      n_chk++;
      if (rd[d] !== 64'd0) begin
        n_fail++; $display("FAIL reset_rdata[%0d] got %h want 0", d, rd[d]);
      end
    end
  endtask

  task automatic test_mtime_count();
    logic [63:0] r; logic e, ok, st, ta; longint ea; logic seen;
    seen = 1'b0;
    repeat (10) begin
      @(negedge clk);
      seen |= (tirq[0] !== 1'b0);
    end
    access(0, 1'b0, A_MT, 64'd0, 8'h00, 0, r, e, ea, ok, st, ta);
    n_chk++;
    if (r !== 64'd10 || e !== 1'b0) begin
      n_fail++; $display("FAIL mtime_after_10 got %0d err %b want 10 err 0", r, e);
    end
    n_chk++;
    if (seen || !ok) begin
      n_fail++; $display("FAIL idle_tirq_handshake got tirq_seen %b ok %b want 0 1", seen, ok);
    end
  endtask

  task automatic test_prescale();
    logic [63:0] r; logic e, ok, st, ta; longint ea;
    access(1, 1'b1, A_MT, 64'd0, 8'hFF, 0, r, e, ea, ok, st, ta);
    repeat (15) @(negedge clk);
    access(1, 1'b0, A_MT, 64'd0, 8'h00, 0, r, e, ea, ok, st, ta);
    n_chk++;
    if (r !== 64'd4 || r !== exp_rd(1, A_MT, ea)) begin
      n_fail++; $display("FAIL prescale_div4 got %0d want 4 (model %0d)", r, exp_rd(1, A_MT, ea));
    end
  endtask

  task automatic test_timer();
    logic [63:0] r; logic e, ok, st, ta; longint ea, want, rise; int mism;
    access(0, 1'b1, A_MT, 64'h10, 8'hFF, 0, r, e, ea, ok, st, ta);
    want = c0[0] + 16;
    access(0, 1'b1, A_CMP, 64'h20, 8'hFF, 0, r, e, ea, ok, st, ta);
    mism = 0; rise = -1;
    repeat (30) begin
      @(negedge clk);
      if (tirq[0] !== (mt(0, cyc) >= cmp[0])) mism++;
      if (tirq[0] === 1'b1 && rise < 0) rise = cyc;
    end
    n_chk++;
    if (mism != 0) begin
      n_fail++; $display("FAIL timer_track got %0d cycle mismatches want 0", mism);
    end
    n_chk++;
    if (rise != want) begin
      n_fail++; $display("FAIL timer_rise_edge got edge %0d want %0d", rise, want);
    end
    access(0, 1'b1, A_CMP, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, 0, r, e, ea, ok, st, ta);
    n_chk++;
    if (ta !== 1'b0 || tirq[0] !== 1'b0) begin
      n_fail++; $display("FAIL timer_drop got at_write %b after %b want 0 0", ta, tirq[0]);
    end
  endtask

  task automatic test_wrap();
    logic [63:0] r; logic e, ok, st, ta; longint ea;
    access(0, 1'b1, A_MT, 64'hFFFF_FFFF_FFFF_FFFE, 8'hFF, 0, r, e, ea, ok, st, ta);
    @(negedge clk);
    access(0, 1'b0, A_MT, 64'd0, 8'h00, 0, r, e, ea, ok, st, ta);
    n_chk++;
    if (r !== 64'd0 || r !== exp_rd(0, A_MT, ea)) begin
      n_fail++; $display("FAIL mtime_wrap got %h want 0", r);
    end
    access(0, 1'b1, A_CMP, 64'h1234, 8'h0F, 0, r, e, ea, ok, st, ta);
    access(0, 1'b0, A_CMP, 64'd0, 8'h00, 0, r, e, ea, ok, st, ta);
    n_chk++;
    if (r !== 64'hFFFF_FFFF_0000_1234) begin
      n_fail++; $display("FAIL cmp_partial got %h want ffffffff00001234", r);
    end
    access(0, 1'b1, A_MT, 64'hAAAA_BBBB_0000_1234, 8'h0F, 0, r, e, ea, ok, st, ta);
    access(0, 1'b0, A_MT, 64'd0, 8'h00, 0, r, e, ea, ok, st, ta);
    n_chk++;
    if (r !== exp_rd(0, A_MT, ea) || r[63:32] !== 32'd0) begin
      n_fail++; $display("FAIL mtime_partial got %h want %h", r, exp_rd(0, A_MT, ea));
    end
    access(0, 1'b1, A_CMP, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, 0, r, e, ea, ok, st, ta);
  endtask

  task automatic test_unmapped();
    logic [63:0] r; logic e, ok, st, ta; longint ea;
    access(0, 1'b0, A_BAD, 64'd0, 8'h00, 5, r, e, ea, ok, st, ta);
    n_chk++;
    if (e !== 1'b1 || r !== 64'd0) begin
      n_fail++; $display("FAIL unmapped_read got err %b rdata %h want 1 0", e, r);
    end
    n_chk++;
    if (st !== 1'b1 || ok !== 1'b1) begin
      n_fail++; $display("FAIL resp_hold got stable %b ok %b want 1 1", st, ok);
    end
    access(0, 1'b1, A_BAD, 64'h5, 8'hFF, 0, r, e, ea, ok, st, ta);
    access(0, 1'b0, A_CMP, 64'd0, 8'h00, 0, r, e, ea, ok, st, ta);
    n_chk++;
    if (r !== cmp[0]) begin
      n_fail++; $display("FAIL unmapped_write_side_effect got cmp %h want %h", r, cmp[0]);
    end
  endtask

  task automatic test_msip();
    logic [63:0] r; logic e, ok, st, ta; longint ea;
    access(0, 1'b1, A_MSIP, 64'd1, 8'h01, 0, r, e, ea, ok, st, ta);
    n_chk++;
    if (sirq[0] !== msip_exp(0) || e !== 1'b0) begin
      n_fail++; $display("FAIL msip_write got sirq %b err %b want %b 0", sirq[0], e, msip_exp(0));
    end
    access(0, 1'b0, A_MSIP, 64'd0, 8'h00, 0, r, e, ea, ok, st, ta);
    n_chk++;
    if (r !== exp_rd(0, A_MSIP, ea) || e !== 1'b0) begin
      n_fail++; $display("FAIL msip_read got %h err %b want %h 0", r, e, exp_rd(0, A_MSIP, ea));
    end
    access(0, 1'b1, A_MSIP, 64'd0, 8'h01, 0, r, e, ea, ok, st, ta);
  endtask

  task automatic test_back_to_back();
    logic [63:0] r1, r2; logic e, ok1, ok2, ok3, st, ta; longint ea1, ea2, ea3;
    logic [63:0] v;
    v = {$urandom, $urandom};
    access(1, 1'b1, A_CMP, v, 8'hFF, 0, r1, e, ea1, ok1, st, ta);
    access(1, 1'b0, A_CMP, 64'd0, 8'h00, 0, r1, e, ea2, ok2, st, ta);
    access(1, 1'b0, A_MT, 64'd0, 8'h00, 0, r2, e, ea3, ok3, st, ta);
    n_chk++;
    if (ea2 - ea1 != 2 || ea3 - ea2 != 2 || !(ok1 & ok2 & ok3)) begin
      n_fail++; $display("FAIL b2b_spacing got gaps %0d %0d ok %b%b%b want 2 2 111",
                         ea2 - ea1, ea3 - ea2, ok1, ok2, ok3);
    end
    n_chk++;
    if (r1 !== v || r2 !== exp_rd(1, A_MT, ea3)) begin
      n_fail++; $display("FAIL b2b_data got cmp %h mt %h want %h %h", r1, r2, v, exp_rd(1, A_MT, ea3));
    end
    access(1, 1'b1, A_CMP, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, 0, r1, e, ea1, ok1, st, ta);
  endtask

  task automatic test_reset_in_resp();
    logic [63:0] r; logic e, ok, st, ta; longint ea;
    rv[0] = 1'b1; wen[0] = 1'b0; addr[0] = A_MT; rsr[0] = 1'b0;
    @(negedge clk);
    rv[0] = 1'b0;
    n_chk++;
    if (rsv[0] !== 1'b1) begin
      n_fail++; $display("FAIL rir_pending got valid %b want 1", rsv[0]);
    end
    rst_n = 1'b0;
    @(negedge clk);
    n_chk++;
    if (rsv[0] !== 1'b0 || rr[0] !== 1'b1 || rd[0] !== 64'd0) begin
      n_fail++; $display("FAIL rir_drop got valid %b ready %b rdata %h want 0 1 0", rsv[0], rr[0], rd[0]);
    end
    rst_n = 1'b1;
    model_reset(cyc);
    access(0, 1'b0, A_MT, 64'd0, 8'h00, 0, r, e, ea, ok, st, ta);
    n_chk++;
    if (r !== exp_rd(0, A_MT, ea) || !ok) begin
      n_fail++; $display("FAIL rir_resume got %h ok %b want %h 1", r, ok, exp_rd(0, A_MT, ea));
    end
  endtask

  task automatic test_random();
    logic [63:0] r, v, ex; logic e, ok, st, ta, w; longint ea;
    logic [31:0] a; logic [7:0] s; int d, sel, bad;
    logic [31:0] bad_tbl[4];
    bad_tbl[0] = A_BAD; bad_tbl[1] = 32'h0200_0008; bad_tbl[2] = 32'h0200_BFF0; bad_tbl[3] = 32'h0200_4008;
    bad = 0;
    for (int i = 0; i < 60; i++) begin
      d = int'($urandom_range(0, 1));
      sel = int'($urandom_range(0, 4));
      a = (sel == 0) ? A_MSIP : (sel == 1) ? A_CMP : (sel == 2) ? A_MT : bad_tbl[$urandom_range(0, 3)];
      w = 1'($urandom_range(0, 1));
      v = {$urandom, $urandom};
      s = 8'($urandom);
      repeat ($urandom_range(0, 2)) @(negedge clk);
      access(d, w, a, v, s, int'($urandom_range(0, 2)), r, e, ea, ok, st, ta);
      ex = w ? 64'd0 : exp_rd(d, a, ea);
      if (r !== ex || e !== exp_err(a) || !ok || !st || tirq[d] !== (mt(d, cyc) >= cmp[d]) ||
          sirq[d] !== msip_exp(d)) begin
        bad++;
        if (bad <= 5)
          $display("FAIL random[%0d] dut%0d w%b a %h got r %h e %b tirq %b sirq %b want r %h e %b tirq %b sirq %b",
                   i, d, w, a, r, e, tirq[d], sirq[d], ex, exp_err(a), mt(d, cyc) >= cmp[d], msip_exp(d));
      end
    end
    n_chk++;
    if (bad != 0) n_fail++;
  endtask

  initial begin
    tdiv[0] = 1; tdiv[1] = 4;
    for (int d = 0; d < 2; d++) begin
      rv[d] = 1'b0; wen[d] = 1'b0; rsr[d] = 1'b0; addr[d] = '0; wd[d] = '0; ws[d] = '0;
    end
    model_reset(0);
    test_reset();
    test_mtime_count();
    test_prescale();
    test_timer();
    test_wrap();
    test_unmapped();
    test_msip();
    test_back_to_back();
    test_reset_in_resp();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "timeout");
  end
endmodule
